// File: rtl/uart_rx_msg_checker.sv
// Bit-per-clock UART receiver (8N1, no oversampling) feeding a matcher that
// counts complete occurrences of the message "Hello World!\n".
module uart_rx_msg_checker #(
  parameter int MSG_LEN = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       msg_ok,
  output logic [7:0] msg_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_STOP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic [3:0] idx_q, idx_d;
  logic       msg_ok_q, msg_ok_d;
  logic [7:0] msg_count_q, msg_count_d;

  function automatic logic [7:0] msg_char(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'h48;
      4'd1:    c = 8'h65;
      4'd2:    c = 8'h6C;
      4'd3:    c = 8'h6C;
      4'd4:    c = 8'h6F;
      4'd5:    c = 8'h20;
      4'd6:    c = 8'h57;
      4'd7:    c = 8'h6F;
      4'd8:    c = 8'h72;
      4'd9:    c = 8'h6C;
      4'd10:   c = 8'h64;
      4'd11:   c = 8'h21;
      4'd12:   c = 8'h0A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Receiver: start edge, 8 data edges, stop edge; result flags are registered
  // so they appear in the cycle after the stop-bit edge.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!uart_rx) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        shift_d   = {uart_rx, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (uart_rx) begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_BREAK;
        end
      end
      S_BREAK: begin
        if (uart_rx) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Matcher: a mismatching "H" is itself a valid first character, so restart at 1.
  always_comb begin
    idx_d       = idx_q;
    msg_ok_d    = 1'b0;
    msg_count_d = msg_count_q;
    if (rx_valid_q) begin
      if (rx_data_q == msg_char(idx_q)) begin
        if (idx_q == LAST_IDX) begin
          idx_d       = 4'd0;
          msg_ok_d    = 1'b1;
          msg_count_d = msg_count_q + 8'd1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else if (rx_data_q == 8'h48) begin
        idx_d = 4'd1;
      end else begin
        idx_d = 4'd0;
      end
    end else if (frame_err_q) begin
      idx_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      idx_q       <= 4'd0;
      msg_ok_q    <= 1'b0;
      msg_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      idx_q       <= idx_d;
      msg_ok_q    <= msg_ok_d;
      msg_count_q <= msg_count_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign msg_ok    = msg_ok_q;
  assign msg_count = msg_count_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_msg_checker.sv
// Bench for uart_rx_msg_checker: bytes are serialised onto uart_rx and the
// expected received bytes are queued for the monitor to compare against rx_data.
module tb_uart_rx_msg_checker;

  logic       clk;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       msg_ok;
  logic [7:0] msg_count;
  logic       busy;

  uart_rx_msg_checker #(.MSG_LEN(13)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .msg_ok    (msg_ok),
    .msg_count (msg_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_vld, n_ferr, n_ok, busy_cycles;
  int start_cyc, last_vld_cyc, prev_vld_cyc;
  logic [7:0] exp_q[$];
  logic [7:0] msg_bytes[13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                                8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_counts();
    n_vld = 0; n_ferr = 0; n_ok = 0; busy_cycles = 0;
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    uart_rx = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic expect_vld);
    if (expect_vld) exp_q.push_back(b);
    drive_bit(1'b0);
    start_cyc = cyc + 1;
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_data"},   rx_data,   0);
    check({tag, "_rx_valid"},  rx_valid,  0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_msg_ok"},    msg_ok,    0);
    check({tag, "_msg_count"}, msg_count, 0);
    check({tag, "_busy"},      busy,      0);
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  logic prev_vld = 1'b0, prev_ferr = 1'b0, prev_ok = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      busy_cycles += int'(busy);
      if (rx_valid && frame_err) check("vld_ferr_exclusive", 1, 0);
      if (rx_valid && prev_vld)  check("rx_valid_one_cycle", 1, 0);
      if (frame_err && prev_ferr) check("frame_err_one_cycle", 1, 0);
      if (msg_ok && prev_ok)     check("msg_ok_one_cycle", 1, 0);
      if (rx_valid) begin
        n_vld++;
        prev_vld_cyc = last_vld_cyc;
        last_vld_cyc = cyc;
        if (exp_q.size() == 0) check("sb_unexpected_rx_valid", 1, 0);
        else check("sb_rx_data", rx_data, exp_q.pop_front());
      end
      if (frame_err) n_ferr++;
      if (msg_ok) n_ok++;
      prev_vld  = rx_valid;
      prev_ferr = frame_err;
      prev_ok   = msg_ok;
    end
  end

  initial begin
    uart_rx = 1'b1;
    reset   = 1'b0;
    clear_counts();
    last_vld_cyc = 0;
    prev_vld_cyc = 0;
    start_cyc    = 0;
    #1 reset = 1'b1;
    #2;
    check_outputs_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Single "H" with a good stop bit
    clear_counts();
    send_byte(8'h48, 1'b1, 1'b1);
    idle(4);
    check("h_rx_valid_count", n_vld, 1);
    check("h_frame_err_count", n_ferr, 0);
    check("h_busy_cycles", busy_cycles, 9);
    check("h_latency_edges", last_vld_cyc - start_cyc + 1, 10);
    check("h_sb_drained", exp_q.size(), 0);

    // Full message twice, one idle bit between frames
    for (int rep = 1; rep <= 2; rep++) begin
      clear_counts();
      for (int i = 0; i < 13; i++) begin
        send_byte(msg_bytes[i], 1'b1, 1'b1);
        if (i != 12) idle(1);
      end
      idle(11);
      check("msg_rx_valid_count", n_vld, 13);
      check("msg_ok_count", n_ok, 1);
      check("msg_count", msg_count, rep);
      check("msg_sb_drained", exp_q.size(), 0);
    end

    // Framing error on 0x41 followed by a held-low break
    send_byte(8'h48, 1'b1, 1'b1);
    idle(3);
    check("pre_ferr_idx", dut.idx_q, 1);
    clear_counts();
    send_byte(8'h41, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b0);
    idle(5);
    check("ferr_count", n_ferr, 1);
    check("ferr_rx_valid_count", n_vld, 0);
    check("ferr_busy_cycles", busy_cycles, 15);
    check("ferr_idx", dut.idx_q, 0);
    check("ferr_rx_data_kept", rx_data, 8'h48);

    // Asynchronous reset during data bit 4 of "e", then "A"
    clear_counts();
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(logic'((8'h65 >> i) & 1));
    #2 reset = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    check("async_rst_idx", dut.idx_q, 0);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_byte(8'h41, 1'b1, 1'b1);
    idle(4);
    check("rst_rx_valid_count", n_vld, 1);
    check("rst_sb_drained", exp_q.size(), 0);

    // Restart on a repeated "H": H e H e l l o ...
    clear_counts();
    send_byte(8'h48, 1'b1, 1'b1); idle(1);
    send_byte(8'h65, 1'b1, 1'b1); idle(1);
    send_byte(8'h48, 1'b1, 1'b1); idle(2);
    check("restart_idx", dut.idx_q, 1);
    for (int i = 1; i < 13; i++) begin
      send_byte(msg_bytes[i], 1'b1, 1'b1);
      idle(1);
    end
    idle(10);
    check("restart_rx_valid_count", n_vld, 15);
    check("restart_msg_ok_count", n_ok, 1);
    check("restart_msg_count", msg_count, 1);

    // Back-to-back frames with no idle bit between them
    clear_counts();
    send_byte(8'h48, 1'b1, 1'b1);
    send_byte(8'h65, 1'b1, 1'b1);
    idle(6);
    check("b2b_rx_valid_count", n_vld, 2);
    check("b2b_gap_cycles", last_vld_cyc - prev_vld_cyc, 10);
    check("b2b_idx", dut.idx_q, 2);
    check("b2b_sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
